// File: rtl/burst_reader_pkg.sv
// Shared types and helpers for the burst_reader Avalon-MM read master.
// Holds the controller state encoding, the default buffer geometry and the burst sizing helper.
package burst_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        DATA  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int FIFO_DEPTH_DEF = 32;
    localparam int FIFO_AW        = $clog2(FIFO_DEPTH_DEF);

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_reader_fifo.sv
// Show-ahead stream buffer: storage array plus a registered head word, so the
// head data/valid leave the block straight from flops. count covers array and head.
module stream_fifo
    import burst_reader_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 1 << FIFO_AW
) (
    input  logic                       clock,
    input  logic                       clock_areset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      mem_cnt_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] head_r;
    logic             head_valid_r;

    logic pop_s;
    logic load_s;
    logic mem_rd_s;
    logic bypass_s;
    logic mem_wr_s;

    // Head refill decision: an empty array lets a push land straight in the head.
    always_comb begin
        pop_s    = head_valid_r & rd_en;
        load_s   = ~head_valid_r | pop_s;
        mem_rd_s = load_s & (mem_cnt_r != {(AW + 1){1'b0}});
        bypass_s = load_s & (mem_cnt_r == {(AW + 1){1'b0}}) & wr_en;
        mem_wr_s = wr_en & ~bypass_s;
    end

    // Storage array write port; contents are don't-care once pointers reset.
    always_ff @(posedge clock) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head word.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            mem_cnt_r    <= {(AW + 1){1'b0}};
            count_r      <= {(AW + 1){1'b0}};
            head_r       <= {WIDTH{1'b0}};
            head_valid_r <= 1'b0;
        end else begin
            if (mem_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (mem_rd_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                head_r       <= mem_r[rd_ptr_r];
                head_valid_r <= 1'b1;
            end else if (bypass_s) begin
                head_r       <= wr_data;
                head_valid_r <= 1'b1;
            end else if (load_s) begin
                head_valid_r <= 1'b0;
            end
            case ({mem_wr_s, mem_rd_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_ONE;
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_ONE;
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            case ({wr_en, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data  = head_r;
    assign rd_valid = head_valid_r;
    assign count    = count_r;

endmodule

// File: rtl/burst_reader.sv
// Avalon-MM burst read master: splits a (address, length) command into bursts of
// at most MAXBURST beats, one outstanding at a time, and streams the words out.
module burst_reader
    import burst_reader_pkg::*;
#(
    parameter int WIDTHA     = 10,
    parameter int WIDTHD     = 16,
    parameter int WIDTHB     = 8,
    parameter int WIDTHL     = 16,
    parameter int MAXBURST   = 16,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              clock_areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTHA-1:0] cmd_address,
    input  logic [WIDTHL-1:0] cmd_length,
    output logic [WIDTHA-1:0] m_address,
    output logic [WIDTHB-1:0] m_burstcount,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [WIDTHD-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [WIDTHD-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t state_r;
    state_t state_next_s;

    logic [WIDTHA-1:0] addr_r;
    logic [WIDTHL-1:0] remaining_r;
    logic [WIDTHB-1:0] bsize_r;
    logic [WIDTHB-1:0] beats_r;
    logic              m_read_r;
    logic [WIDTHA-1:0] m_address_r;
    logic [WIDTHB-1:0] m_burstcount_r;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              done_r;

    logic [WIDTHL-1:0] len_src_s;
    logic [WIDTHL-1:0] bsize_full_s;
    logic [WIDTHB-1:0] bsize_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW-1:0]     free_s;
    logic              space_ok_s;
    logic              final_beat_s;
    logic              last_s;
    logic              accept_s;
    logic              load_burst_s;
    logic              grant_s;
    logic              push_s;
    logic [WIDTHD:0]   fifo_head_s;
    logic              fifo_valid_s;

    // Burst sizing and buffer space test; in IDLE the incoming length is sized so
    // the first request can go out right after the command handshake.
    always_comb begin
        len_src_s    = (state_r == IDLE) ? cmd_length : remaining_r;
        bsize_full_s = WIDTHL'(min_len(32'(len_src_s), 32'(MAXBURST)));
        bsize_s      = WIDTHB'(bsize_full_s);
        free_s       = CW'(FIFO_DEPTH) - fifo_count_s;
        space_ok_s   = (32'(free_s) >= 32'(bsize_s));
        final_beat_s = (beats_r == (bsize_r - WIDTHB'(1)));
        last_s       = (remaining_r == {WIDTHL{1'b0}}) & final_beat_s;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        load_burst_s = 1'b0;
        grant_s      = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    if (cmd_length == {WIDTHL{1'b0}}) begin
                        state_next_s = DONE;
                    end else if (space_ok_s) begin
                        state_next_s = ISSUE;
                        load_burst_s = 1'b1;
                    end else begin
                        state_next_s = CHECK;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CHECK: begin
                if (space_ok_s) begin
                    state_next_s = ISSUE;
                    load_burst_s = 1'b1;
                end else begin
                    state_next_s = CHECK;
                end
            end
            ISSUE: begin
                if (!m_waitrequest) begin
                    grant_s      = 1'b1;
                    state_next_s = DATA;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DATA: begin
                if (m_readdatavalid) begin
                    push_s = 1'b1;
                    if (final_beat_s) begin
                        if (remaining_r != {WIDTHL{1'b0}}) begin
                            state_next_s = CHECK;
                        end else begin
                            state_next_s = DRAIN;
                        end
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            DRAIN: begin
                if (fifo_valid_s && out_ready && fifo_head_s[0]) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status outputs; cmd_ready waits one cycle after DONE so it only ever shows in IDLE.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (state_next_s == IDLE) && (state_r != DONE);
            busy_r      <= (state_next_s != IDLE) && (state_next_s != DONE);
            done_r      <= (state_next_s == DONE);
        end
    end

    // Command bookkeeping and the Avalon request registers.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            addr_r         <= {WIDTHA{1'b0}};
            remaining_r    <= {WIDTHL{1'b0}};
            bsize_r        <= {WIDTHB{1'b0}};
            beats_r        <= {WIDTHB{1'b0}};
            m_read_r       <= 1'b0;
            m_address_r    <= {WIDTHA{1'b0}};
            m_burstcount_r <= {WIDTHB{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r      <= cmd_address;
                remaining_r <= cmd_length;
            end
            if (load_burst_s) begin
                bsize_r        <= bsize_s;
                m_read_r       <= 1'b1;
                m_address_r    <= (state_r == IDLE) ? cmd_address : addr_r;
                m_burstcount_r <= bsize_s;
            end
            if (grant_s) begin
                m_read_r    <= 1'b0;
                addr_r      <= addr_r + WIDTHA'(bsize_r);
                remaining_r <= remaining_r - WIDTHL'(bsize_r);
                beats_r     <= {WIDTHB{1'b0}};
            end
            if (push_s) begin
                beats_r <= beats_r + WIDTHB'(1);
            end
        end
    end

    stream_fifo #(
        .WIDTH (WIDTHD + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .wr_en          (push_s),
        .wr_data        ({m_readdata, last_s}),
        .rd_en          (out_ready),
        .rd_data        (fifo_head_s),
        .rd_valid       (fifo_valid_s),
        .count          (fifo_count_s)
    );

    assign cmd_ready    = cmd_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign m_read       = m_read_r;
    assign m_address    = m_address_r;
    assign m_burstcount = m_burstcount_r;
    assign out_data     = fifo_head_s[WIDTHD:1];
    assign out_last     = fifo_head_s[0];
    assign out_valid    = fifo_valid_s;

endmodule

// File: tb/tb_burst_reader.sv
// Scoreboard bench for burst_reader: a burst RAM slave (mem[i]=i) answers reads,
// expected bursts and stream words are queued per command and checked by monitors.
module tb_burst_reader;

    logic        clock = 1'b0;
    logic        clock_areset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_address;
    logic [15:0] cmd_length;
    logic [9:0]  m_address;
    logic [7:0]  m_burstcount;
    logic        m_read;
    logic        m_waitrequest;
    logic [15:0] m_readdata;
    logic        m_readdatavalid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    burst_reader dut (
        .clock           (clock),
        .clock_areset_n  (clock_areset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_address     (cmd_address),
        .cmd_length      (cmd_length),
        .m_address       (m_address),
        .m_burstcount    (m_burstcount),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    typedef struct { logic [9:0] addr; logic [7:0] cnt; } burst_t;
    typedef struct { logic [15:0] data; logic last; } word_t;

    burst_t exp_bursts[$];
    word_t  exp_words[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_grants = 0;
    int done_cnt = 0;
    int wait_cfg = 0;
    bit stray_req = 1'b0;
    bit quiet_win = 1'b0;
    int quiet_hits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_burst(input logic [9:0] a, input logic [7:0] c);
        burst_t b;
        b.addr = a;
        b.cnt  = c;
        exp_bursts.push_back(b);
    endtask

    // Slave memory holds mem[i]=i, so the word at address a is a itself (mod 1024).
    task automatic exp_range(input int start, input int n);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.data = 16'((start + k) % 1024);
            w.last = (k == n - 1);
            exp_words.push_back(w);
        end
    endtask

    // Burst RAM slave model with optional waitrequest hold per request.
    int         ret_left = 0;
    logic [9:0] ret_addr;
    bit         grant_pending = 1'b0;
    logic [9:0] g_addr;
    logic [7:0] g_cnt;
    bit         req_seen = 1'b0;
    int         wait_left = 0;
    logic [9:0] req_addr;
    logic [7:0] req_cnt;

    initial begin
        burst_t b;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = 16'h0000;
        forever begin
            @(posedge clock);
            #1;
            if (grant_pending) begin
                ret_addr      = g_addr;
                ret_left      = int'(g_cnt);
                grant_pending = 1'b0;
            end
            if (ret_left > 0) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 16'(ret_addr);
                ret_addr        = ret_addr + 10'd1;
                ret_left--;
            end else if (stray_req) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 16'hBEEF;
                stray_req       = 1'b0;
            end else begin
                m_readdatavalid = 1'b0;
            end
            if (m_read) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    wait_left = wait_cfg;
                    req_addr  = m_address;
                    req_cnt   = m_burstcount;
                end else begin
                    check("addr_stable", 32'(m_address), 32'(req_addr));
                    check("count_stable", 32'(m_burstcount), 32'(req_cnt));
                end
                if (wait_left > 0) begin
                    m_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    m_waitrequest = 1'b0;
                    grant_pending = 1'b1;
                    g_addr        = m_address;
                    g_cnt         = m_burstcount;
                    req_seen      = 1'b0;
                    n_grants++;
                    if (exp_bursts.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL burst_unexpected: got addr 0x%0h count %0d, expected none", m_address, m_burstcount);
                    end else begin
                        b = exp_bursts.pop_front();
                        check("burst_addr", 32'(m_address), 32'(b.addr));
                        check("burst_count", 32'(m_burstcount), 32'(b.cnt));
                    end
                end
            end else begin
                m_waitrequest = 1'b0;
                req_seen      = 1'b0;
            end
        end
    end

    // Stream/done monitor, sampled on the falling edge.
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    bit          prev_done = 1'b0;

    initial begin
        word_t w;
        forever begin
            @(negedge clock);
            if (!clock_areset_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (quiet_win && (m_read || out_valid)) quiet_hits++;
                if (out_valid && prev_stall) check("hold_data", 32'(out_data), 32'(prev_data));
                if (out_valid && out_ready) begin
                    if (exp_words.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL word_unexpected: got 0x%0h, expected none", out_data);
                    end else begin
                        w = exp_words.pop_front();
                        check("word_data", 32'(out_data), 32'(w.data));
                        check("word_last", 32'(out_last), 32'(w.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (done) begin
                    check("done_pulse", 32'(prev_done), 32'd0);
                    done_cnt++;
                end
                prev_done = done;
            end
        end
    end

    task automatic send_cmd(input logic [9:0] a, input logic [15:0] len);
        int i;
        @(posedge clock);
        #1;
        cmd_valid   = 1'b1;
        cmd_address = a;
        cmd_length  = len;
        i = 0;
        do begin
            @(negedge clock);
            i++;
        end while (!cmd_ready && i < 200);
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_accept: got no cmd_ready, expected handshake within 200 cycles");
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clock);
        check("done_seen", 32'(done_cnt), 32'(target));
    endtask

    task automatic check_all_zero(input string name);
        check(name, {22'd0, m_read, m_address != 10'd0, m_burstcount != 8'd0, out_valid,
                     out_last, busy, done, cmd_ready, 2'b00}, 32'd0);
    endtask

    int g0;

    initial begin
        clock_areset_n = 1'b0;
        cmd_valid      = 1'b0;
        cmd_address    = 10'h000;
        cmd_length     = 16'd0;
        out_ready      = 1'b1;
        #2;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clock);
        #1 clock_areset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Short command: one 5-beat burst.
        exp_burst(10'h010, 8'd5);
        exp_range(16'h010, 5);
        send_cmd(10'h010, 16'd5);
        wait_done(1, 200);
        @(negedge clock);
        check("short_busy", 32'(busy), 32'd0);
        check("short_words_left", 32'(exp_words.size()), 32'd0);

        // Splitting into 16/16/8.
        exp_burst(10'h000, 8'd16);
        exp_burst(10'h010, 8'd16);
        exp_burst(10'h020, 8'd8);
        exp_range(0, 40);
        send_cmd(10'h000, 16'd40);
        wait_done(2, 500);
        check("split_grants", 32'(n_grants), 32'd4);

        // Backpressure: buffer fills after two bursts.
        @(posedge clock);
        #1 out_ready = 1'b0;
        exp_burst(10'h000, 8'd16);
        exp_burst(10'h010, 8'd16);
        exp_burst(10'h020, 8'd8);
        exp_range(0, 40);
        g0 = n_grants;
        send_cmd(10'h000, 16'd40);
        repeat (150) @(negedge clock);
        check("bp_grants", 32'(n_grants - g0), 32'd2);
        check("bp_fifo_count", 32'(dut.u_fifo.count), 32'd32);
        check("bp_no_read", 32'(m_read), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_done(3, 500);
        check("bp_total_grants", 32'(n_grants - g0), 32'd3);

        // Zero-length command.
        repeat (2) @(negedge clock);
        quiet_hits = 0;
        quiet_win  = 1'b1;
        send_cmd(10'h055, 16'd0);
        @(negedge clock);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("zero_done_drop", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        quiet_win = 1'b0;
        check("zero_quiet", 32'(quiet_hits), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd4);

        // Address wrap with one waitrequest cycle per request.
        wait_cfg = 1;
        exp_burst(10'h3F8, 8'd16);
        exp_burst(10'h008, 8'd8);
        exp_range(16'h3F8, 24);
        send_cmd(10'h3F8, 16'd24);
        wait_done(5, 500);
        wait_cfg = 0;

        // Reset in the middle of a data phase.
        exp_burst(10'h020, 8'd16);
        exp_range(16'h020, 16);
        send_cmd(10'h020, 16'd16);
        for (int i = 0; i < 100 && !m_readdatavalid; i++) @(negedge clock);
        check("mid_data_reached", 32'(m_readdatavalid), 32'd1);
        repeat (2) @(negedge clock);
        #2 clock_areset_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        exp_words.delete();
        exp_bursts.delete();
        ret_left      = 0;
        grant_pending = 1'b0;
        repeat (2) @(posedge clock);
        #1 clock_areset_n = 1'b1;
        repeat (3) @(posedge clock);

        // Stray beat while idle must not reach the stream.
        quiet_hits = 0;
        quiet_win  = 1'b1;
        #1 stray_req = 1'b1;
        repeat (6) @(negedge clock);
        quiet_win = 1'b0;
        check("stray_quiet", 32'(quiet_hits), 32'd0);

        exp_burst(10'h123, 8'd3);
        exp_range(16'h123, 3);
        send_cmd(10'h123, 16'd3);
        wait_done(6, 200);
        repeat (3) @(negedge clock);
        check("final_words_left", 32'(exp_words.size()), 32'd0);
        check("final_bursts_left", 32'(exp_bursts.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
